alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 90 +++++++++
 tb/tb_alu_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one command at a time through an external ALU and holds the response
// Ports: clk/rst_n (async active-low); cmd_* command handshake (valid/ready, op1, op2, opcode);
// alu_operator1/2, alu_operation drive the ALU, alu_result/alu_overflow come back;
// rsp_* response handshake (valid/ready, result, overflow, error); op_count counts completed responses.
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_op1,
  input  logic [7:0] cmd_op2,
  input  logic [7:0] cmd_opcode,
  output logic [7:0] alu_operator1,
  output logic [7:0] alu_operator2,
  output logic [7:0] alu_operation,
  input  logic [7:0] alu_result,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_overflow,
  output logic       rsp_error,
  output logic [7:0] op_count
);
  typedef enum logic [1:0] {IDLE, OPSET, DRIVE, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [7:0] op1_q, op2_q;
  logic legal, settle_done;
  assign legal = cmd_opcode <= 8'd5;
  assign settle_done = cnt == 4'(SETTLE_CYCLES - 1);
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = cmd_valid ? (legal ? OPSET : RESP) : IDLE;
      OPSET: state_nxt = DRIVE;
      DRIVE: state_nxt = settle_done ? RESP : DRIVE;
      RESP:  state_nxt = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      alu_operator1 <= '0;
      alu_operator2 <= '0;
      alu_operation <= '0;
      rsp_result    <= '0;
      rsp_overflow  <= 1'b0;
      rsp_error     <= 1'b0;
      op_count      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (cmd_valid) begin
          op1_q <= cmd_op1;
          op2_q <= cmd_op2;
          if (legal) alu_operation <= cmd_opcode;
          else begin
            // illegal opcodes never touch the ALU; answer with an error at once
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b1;
          end
        end
        OPSET: begin
          // operands follow the opcode by one edge so the ALU sees the operation select first
          alu_operator1 <= op1_q;
          alu_operator2 <= op2_q;
          cnt           <= '0;
        end
        DRIVE: begin
          cnt <= cnt + 4'd1;
          if (settle_done) begin
            rsp_result   <= alu_result;
            rsp_overflow <= alu_overflow;
            rsp_error    <= 1'b0;
          end
        end
        RESP: if (rsp_ready) op_count <= op_count + 8'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer (default settle and settle=3)
module tb_alu_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [7:0] cmd_op1 = '0, cmd_op2 = '0, cmd_opcode = '0;
  logic cmd_ready, rsp_valid, rsp_overflow, rsp_error, alu_overflow;
  logic [7:0] alu_operator1, alu_operator2, alu_operation, alu_result, rsp_result, op_count;
  logic v3 = 1'b0, r3 = 1'b1;
  logic [7:0] a3 = '0, b3 = '0, o3 = '0;
  logic t_cmd_ready, t_rsp_valid, t_rsp_overflow, t_rsp_error, t_alu_overflow;
  logic [7:0] t_op1, t_op2, t_operation, t_alu_result, t_rsp_result, t_op_count;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  function automatic logic [8:0] alu(input logic [7:0] op, a, b);
    logic [15:0] p;
    p = a * b;
    case (op)
      8'd0: alu = {1'b0, a} + {1'b0, b};
      8'd1: alu = {a < b, a - b};
      8'd2: alu = {1'b0, a & b};
      8'd3: alu = {1'b0, a | b};
      8'd4: alu = {p[15:8] != 0, p[7:0]};
      default: alu = {1'b0, a ^ b};
    endcase
  endfunction
  assign {alu_overflow, alu_result} = alu(alu_operation, alu_operator1, alu_operator2);
  assign {t_alu_overflow, t_alu_result} = alu(t_operation, t_op1, t_op2);
  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_opcode(cmd_opcode),
    .alu_operator1(alu_operator1), .alu_operator2(alu_operator2), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_error(rsp_error), .op_count(op_count)
  );
  alu_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v3), .cmd_ready(t_cmd_ready),
    .cmd_op1(a3), .cmd_op2(b3), .cmd_opcode(o3),
    .alu_operator1(t_op1), .alu_operator2(t_op2), .alu_operation(t_operation),
    .alu_result(t_alu_result), .alu_overflow(t_alu_overflow), .rsp_valid(t_rsp_valid), .rsp_ready(r3),
    .rsp_result(t_rsp_result), .rsp_overflow(t_rsp_overflow), .rsp_error(t_rsp_error), .op_count(t_op_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(input logic [7:0] a, b, op);
    cmd_valid = 1'b1;
    cmd_op1 = a;
    cmd_op2 = b;
    cmd_opcode = op;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_operation", alu_operation, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_operator1", alu_operator1, 0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    drive(8'h05, 8'h03, 8'd0);
    tick;
    chk("add_busy_cmd_ready", cmd_ready, 0);
    chk("add_k_rsp_valid", rsp_valid, 0);
    cmd_valid = 1'b0;
    tick;
    chk("add_k1_rsp_valid", rsp_valid, 0);
    chk("add_operator1", alu_operator1, 8'h05);
    chk("add_operator2", alu_operator2, 8'h03);
    tick;
    chk("add_k2_rsp_valid", rsp_valid, 1);
    chk("add_result", rsp_result, 8'h08);
    chk("add_overflow", rsp_overflow, 0);
    chk("add_error", rsp_error, 0);
    tick;
    chk("add_op_count", op_count, 1);
    chk("add_done_rsp_valid", rsp_valid, 0);
    chk("add_done_cmd_ready", cmd_ready, 1);
    drive(8'hC8, 8'h64, 8'd0);
    tick;
    cmd_valid = 1'b0;
    tick;
    tick;
    chk("ovf_rsp_valid", rsp_valid, 1);
    chk("ovf_result", rsp_result, 8'h2C);
    chk("ovf_overflow", rsp_overflow, 1);
    tick;
    chk("ovf_op_count", op_count, 2);
    rsp_ready = 1'b0;
    drive(8'h11, 8'h22, 8'h09);
    tick;
    cmd_valid = 1'b0;
    tick;
    chk("ill_rsp_valid", rsp_valid, 1);
    chk("ill_result", rsp_result, 0);
    chk("ill_overflow", rsp_overflow, 0);
    chk("ill_error", rsp_error, 1);
    chk("ill_alu_operation", alu_operation, 0);
    chk("ill_operator1", alu_operator1, 8'hC8);
    chk("ill_operator2", alu_operator2, 8'h64);
    rsp_ready = 1'b1;
    tick;
    chk("ill_op_count", op_count, 3);
    chk("ill_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b0;
    drive(8'hF0, 8'h3C, 8'd2);
    tick;
    drive(8'h01, 8'h02, 8'd1);
    tick;
    tick;
    chk("and_error", rsp_error, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, 8'h30);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_alu_operation", alu_operation, 8'd2);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    chk("hold_op_count", op_count, 4);
    chk("hold_idle_cmd_ready", cmd_ready, 1);
    chk("hold_idle_rsp_valid", rsp_valid, 0);
    chk("hold_idle_operation", alu_operation, 8'd2);
    tick;
    chk("second_operation", alu_operation, 8'd1);
    cmd_valid = 1'b0;
    tick;
    tick;
    chk("sub_rsp_valid", rsp_valid, 1);
    chk("sub_result", rsp_result, 8'hFF);
    chk("sub_overflow", rsp_overflow, 1);
    tick;
    chk("sub_op_count", op_count, 5);
    drive(8'h01, 8'h01, 8'd0);
    tick;
    cmd_valid = 1'b0;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_operator1", alu_operator1, 0);
    chk("mid_rst_operation", alu_operation, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_rsp_result", rsp_result, 0);
    chk("mid_rst_rsp_overflow", rsp_overflow, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    chk("mid_rst_hold_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    drive(8'h05, 8'h03, 8'd0);
    tick;
    cmd_valid = 1'b0;
    tick;
    tick;
    chk("post_rst_rsp_valid", rsp_valid, 1);
    chk("post_rst_result", rsp_result, 8'h08);
    tick;
    chk("post_rst_op_count", op_count, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    drive(8'h03, 8'h04, 8'd0);
    repeat (1020) tick;
    chk("wrap_op_count_ff", op_count, 8'hFF);
    repeat (4) tick;
    chk("wrap_op_count_00", op_count, 8'h00);
    cmd_valid = 1'b0;
    v3 = 1'b1;
    a3 = 8'h10;
    b3 = 8'h02;
    o3 = 8'd4;
    tick;
    chk("s3_operation", t_operation, 8'd4);
    chk("s3_operator1_early", t_op1, 0);
    v3 = 1'b0;
    tick;
    chk("s3_operator1", t_op1, 8'h10);
    chk("s3_operator2", t_op2, 8'h02);
    tick;
    chk("s3_k2_rsp_valid", t_rsp_valid, 0);
    tick;
    chk("s3_k3_rsp_valid", t_rsp_valid, 0);
    tick;
    chk("s3_k4_rsp_valid", t_rsp_valid, 1);
    chk("s3_result", t_rsp_result, 8'h20);
    chk("s3_error", t_rsp_error, 0);
    tick;
    chk("s3_op_count", t_op_count, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
